// File: rtl/window_sequencer.sv
// Window sequencer: buffers packer frames in a 2-deep FIFO, numbers them within a
// classification window and pauses the packer for a fixed gap between windows.
module window_sequencer #(
    parameter int FRAME_BW   = 104,
    parameter int N_FRAMES   = 50,
    parameter int GAP_CYCLES = 4,
    localparam int CNT_W     = (N_FRAMES > 1) ? $clog2(N_FRAMES) : 1,
    localparam int GAP_W     = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic                en_i,
    input  logic [FRAME_BW-1:0] data_i,
    input  logic                valid_i,
    output logic                pkt_en_o,
    output logic [FRAME_BW-1:0] data_o,
    output logic                valid_o,
    input  logic                ready_i,
    output logic                last_o,
    output logic [CNT_W-1:0]    frame_cnt_o,
    output logic                overflow_o
);

    typedef enum logic [1:0] {IDLE, RUN, GAP} state_t;

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_FRAMES - 1);
    localparam logic [GAP_W-1:0] GAP_END  = GAP_W'(GAP_CYCLES - 1);

    state_t              state_reg;
    logic [GAP_W-1:0]    gap_cnt_reg;
    logic [1:0]          count_reg;
    logic [FRAME_BW-1:0] head_reg;
    logic [FRAME_BW-1:0] tail_reg;
    logic [CNT_W-1:0]    frame_cnt_reg;
    logic                overflow_reg;
    logic                pkt_en_reg;

    logic pop;
    logic push;
    logic accept;
    logic drop;
    logic last;

    always_comb begin
        last   = (frame_cnt_reg == LAST_IDX) && (count_reg != 2'd0);
        pop    = (count_reg != 2'd0) && ready_i;
        push   = valid_i && (state_reg == RUN);
        // A full FIFO still takes a frame when the head leaves on the same edge.
        accept = push && ((count_reg != 2'd2) || pop);
        drop   = push && (count_reg == 2'd2) && !pop;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_reg     <= IDLE;
            gap_cnt_reg   <= '0;
            count_reg     <= 2'd0;
            head_reg      <= '0;
            tail_reg      <= '0;
            frame_cnt_reg <= '0;
            overflow_reg  <= 1'b0;
            pkt_en_reg    <= 1'b0;
        end else if (!en_i) begin
            state_reg     <= IDLE;
            gap_cnt_reg   <= '0;
            count_reg     <= 2'd0;
            head_reg      <= '0;
            tail_reg      <= '0;
            frame_cnt_reg <= '0;
            overflow_reg  <= 1'b0;
            pkt_en_reg    <= 1'b0;
        end else begin
            // head_reg is the output register; the tail shifts into it on a pop.
            case ({accept, pop})
                2'b11: begin
                    if (count_reg == 2'd2) begin
                        head_reg <= tail_reg;
                        tail_reg <= data_i;
                    end else begin
                        head_reg <= data_i;
                    end
                end
                2'b10: begin
                    count_reg <= count_reg + 2'd1;
                    if (count_reg == 2'd0) head_reg <= data_i;
                    else                   tail_reg <= data_i;
                end
                2'b01: begin
                    count_reg <= count_reg - 2'd1;
                    if (count_reg == 2'd2) head_reg <= tail_reg;
                end
                default: ;
            endcase

            if (pop) begin
                frame_cnt_reg <= (frame_cnt_reg == LAST_IDX) ? '0 : frame_cnt_reg + 1'b1;
            end

            if (drop) overflow_reg <= 1'b1;

            case (state_reg)
                IDLE: begin
                    state_reg  <= RUN;
                    pkt_en_reg <= 1'b1;
                end
                RUN: begin
                    if (pop && last) begin
                        state_reg   <= GAP;
                        gap_cnt_reg <= '0;
                        pkt_en_reg  <= 1'b0;
                    end else begin
                        pkt_en_reg  <= 1'b1;
                    end
                end
                GAP: begin
                    if (gap_cnt_reg == GAP_END) begin
                        state_reg  <= RUN;
                        pkt_en_reg <= 1'b1;
                    end else begin
                        gap_cnt_reg <= gap_cnt_reg + 1'b1;
                    end
                end
                default: begin
                    state_reg  <= IDLE;
                    pkt_en_reg <= 1'b0;
                end
            endcase
        end
    end

    assign pkt_en_o    = pkt_en_reg;
    assign data_o      = head_reg;
    assign valid_o     = (count_reg != 2'd0);
    assign last_o      = last;
    assign frame_cnt_o = frame_cnt_reg;
    assign overflow_o  = overflow_reg;

endmodule

// File: tb/tb_window_sequencer.sv
// Randomised scoreboard bench for window_sequencer with a queue-based reference model.
`timescale 1ns/1ps
module tb_window_sequencer;

    localparam int FBW = 104;
    localparam int NF  = 4;
    localparam int GC  = 3;
    localparam int PH_IDLE = 0;
    localparam int PH_RUN  = 1;
    localparam int PH_GAP  = 2;

    logic           clk_i;
    logic           rst_n_i;
    logic           en_i;
    logic [FBW-1:0] data_i;
    logic           valid_i;
    logic           pkt_en_o;
    logic [FBW-1:0] data_o;
    logic           valid_o;
    logic           ready_i;
    logic           last_o;
    logic [1:0]     frame_cnt_o;
    logic           overflow_o;

    window_sequencer #(.FRAME_BW(FBW), .N_FRAMES(NF), .GAP_CYCLES(GC)) dut (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .en_i        (en_i),
        .data_i      (data_i),
        .valid_i     (valid_i),
        .pkt_en_o    (pkt_en_o),
        .data_o      (data_o),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .last_o      (last_o),
        .frame_cnt_o (frame_cnt_o),
        .overflow_o  (overflow_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [FBW-1:0] d;
        int             cnt;
        bit             last;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: frames accepted/delivered since enable, occupancy and phase.
    int m_occ      = 0;
    int m_acc      = 0;
    int m_del      = 0;
    int m_phase    = PH_IDLE;
    int m_gap_left = 0;
    bit m_ovf      = 1'b0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [FBW-1:0] rnd_frame();
        logic [127:0] t;
        t = {$urandom, $urandom, $urandom, $urandom};
        return t[FBW-1:0];
    endfunction

    task automatic drive(input bit v, input logic [FBW-1:0] d, input bit r);
        valid_i = v;
        data_i  = d;
        ready_i = r;
        @(posedge clk_i);
        #1;
    endtask

    task automatic model_clear();
        m_occ      = 0;
        m_acc      = 0;
        m_del      = 0;
        m_phase    = PH_IDLE;
        m_gap_left = 0;
        m_ovf      = 1'b0;
        exp_q.delete();
    endtask

    initial begin
        bit       pop;
        exp_t     e;
        logic [FBW-1:0] fx;
        rst_n_i = 1'b0;
        en_i    = 1'b0;
        valid_i = 1'b0;
        ready_i = 1'b0;
        data_i  = '0;

        fork
            // Reference model, evaluated on the same edges as the DUT.
            forever begin
                @(posedge clk_i or negedge rst_n_i);
                if (!rst_n_i || !en_i) begin
                    model_clear();
                end else begin
                    pop = (m_occ > 0) && ready_i;
                    if (valid_i && m_phase == PH_RUN) begin
                        if (m_occ < 2 || pop) begin
                            e.d    = data_i;
                            e.cnt  = m_acc % NF;
                            e.last = ((m_acc % NF) == NF - 1);
                            exp_q.push_back(e);
                            m_acc++;
                            m_occ++;
                        end else begin
                            m_ovf = 1'b1;
                        end
                    end
                    if (m_phase == PH_IDLE) begin
                        m_phase = PH_RUN;
                    end else if (m_phase == PH_RUN) begin
                        if (pop && (m_del % NF) == NF - 1) begin
                            m_phase    = PH_GAP;
                            m_gap_left = GC;
                        end
                    end else begin
                        m_gap_left--;
                        if (m_gap_left == 0) m_phase = PH_RUN;
                    end
                    if (pop) begin
                        m_del++;
                        m_occ--;
                    end
                end
            end

            // Monitor: compares DUT outputs with the model away from the active edge.
            forever begin
                @(negedge clk_i);
                if (rst_n_i) begin
                    chk("valid", 128'(valid_o), 128'(m_occ > 0));
                    chk("pkt_en", 128'(pkt_en_o), 128'(m_phase == PH_RUN));
                    chk("overflow", 128'(overflow_o), 128'(m_ovf));
                    if (valid_o) begin
                        if (exp_q.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL unexpected_frame: got data %h expected no frame", data_o);
                        end else begin
                            chk("data", 128'(data_o), 128'(exp_q[0].d));
                            chk("frame_cnt", 128'(frame_cnt_o), 128'(exp_q[0].cnt));
                            chk("last", 128'(last_o), 128'(exp_q[0].last));
                            if (ready_i) begin
                                $display("xfer t=%0t data=%h cnt=%0d last=%0b", $time, data_o, frame_cnt_o, last_o);
                                void'(exp_q.pop_front());
                            end
                        end
                    end else begin
                        chk("frame_cnt_idle", 128'(frame_cnt_o), 128'(m_del % NF));
                        chk("last_idle", 128'(last_o), 128'(0));
                    end
                end
            end

            // Stimulus
            begin
                repeat (3) @(posedge clk_i);
                #1;
                chk("rst_valid", 128'(valid_o), 128'(0));
                chk("rst_pkt_en", 128'(pkt_en_o), 128'(0));
                chk("rst_last", 128'(last_o), 128'(0));
                chk("rst_overflow", 128'(overflow_o), 128'(0));
                chk("rst_frame_cnt", 128'(frame_cnt_o), 128'(0));
                chk("rst_data", 128'(data_o), 128'(0));
                en_i = 1'b1;
                #2 rst_n_i = 1'b1;
                #1 chk("release_pkt_en", 128'(pkt_en_o), 128'(0));
                @(posedge clk_i);
                #1;

                // Basic window: four frames 13 cycles apart, then the gap.
                for (int i = 0; i < NF; i++) begin
                    drive(1'b1, rnd_frame(), 1'b1);
                    repeat (12) drive(1'b0, '0, 1'b1);
                end

                // Backpressure: two frames held, then released in order.
                drive(1'b1, rnd_frame(), 1'b0);
                drive(1'b1, rnd_frame(), 1'b0);
                repeat (3) drive(1'b0, '0, 1'b0);
                repeat (3) drive(1'b0, '0, 1'b1);

                // Full FIFO with a pop on the same edge as the push.
                drive(1'b1, rnd_frame(), 1'b0);
                drive(1'b1, rnd_frame(), 1'b0);
                drive(1'b1, rnd_frame(), 1'b1);
                repeat (8) drive(1'b0, '0, 1'b1);

                // Overflow: third frame dropped while stalled.
                fx = rnd_frame();
                drive(1'b1, fx, 1'b0);
                drive(1'b1, rnd_frame(), 1'b0);
                drive(1'b1, rnd_frame(), 1'b0);
                repeat (2) drive(1'b0, '0, 1'b0);
                repeat (3) drive(1'b0, '0, 1'b1);

                // Close the window, then strobe valid_i through the gap.
                drive(1'b1, rnd_frame(), 1'b1);
                drive(1'b0, '0, 1'b1);
                repeat (3) drive(1'b1, rnd_frame(), 1'b1);
                repeat (4) drive(1'b0, '0, 1'b1);

                // Abort mid-window with frames stalled, then restart.
                drive(1'b1, rnd_frame(), 1'b0);
                drive(1'b1, rnd_frame(), 1'b0);
                en_i = 1'b0;
                drive(1'b0, '0, 1'b0);
                en_i = 1'b1;
                drive(1'b0, '0, 1'b1);
                repeat (3) drive(1'b1, rnd_frame(), 1'b1);
                repeat (3) drive(1'b0, '0, 1'b1);

                // Randomised traffic with occasional disables.
                repeat (400) begin
                    en_i = ($urandom_range(0, 79) != 0);
                    drive($urandom_range(0, 2) == 0, rnd_frame(), $urandom_range(0, 2) != 0);
                end
                en_i = 1'b1;
                repeat (4) drive(1'b0, '0, 1'b1);

                // Asynchronous reset pulse mid-cycle, mid-window.
                drive(1'b1, rnd_frame(), 1'b0);
                drive(1'b1, rnd_frame(), 1'b0);
                #1 rst_n_i = 1'b0;
                #1;
                chk("arst_valid", 128'(valid_o), 128'(0));
                chk("arst_pkt_en", 128'(pkt_en_o), 128'(0));
                chk("arst_last", 128'(last_o), 128'(0));
                chk("arst_overflow", 128'(overflow_o), 128'(0));
                chk("arst_frame_cnt", 128'(frame_cnt_o), 128'(0));
                chk("arst_data", 128'(data_o), 128'(0));
                #1 rst_n_i = 1'b1;
                @(posedge clk_i);
                #1;
                repeat (40) drive($urandom_range(0, 1) == 0, rnd_frame(), $urandom_range(0, 3) != 0);
                repeat (6) drive(1'b0, '0, 1'b1);
            end
        join_any
        disable fork;

        chk("drained", 128'(exp_q.size()), 128'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
